// File: rtl/timer_if.sv
// Control and status bundle between a timer_ctrl instance and the logic that drives it.
// The master side issues commands and configuration; the slave side (the timer) reports status.
interface timer_if #(
    parameter int WIDTH      = 4,
    parameter int PRESCALE_W = 4
);
    logic                  start;
    logic                  stop;
    logic                  pause;
    logic [WIDTH-1:0]      load_val;
    logic [PRESCALE_W-1:0] prescale;
    logic                  mode;
    logic                  dir;
    logic [WIDTH-1:0]      count;
    logic                  busy;
    logic                  tick;
    logic                  done;
    logic [1:0]            state;

    modport master (
        output start, stop, pause, load_val, prescale, mode, dir,
        input  count, busy, tick, done, state
    );

    modport slave (
        input  start, stop, pause, load_val, prescale, mode, dir,
        output count, busy, tick, done, state
    );
endinterface

// File: rtl/timer_ctrl.sv
// Interval timer controller: one-shot/periodic, up/down, prescaled, with pause and stop.
// state | meaning
// IDLE  | waiting for start, config is captured into shadow registers on start
// RUN   | prescaler and counter advancing
// PAUSE | previous edge saw pause high; count and prescaler frozen
// DONE  | one cycle after a one-shot terminal step, then back to IDLE
module timer_ctrl #(
    parameter int WIDTH      = 4,
    parameter int PRESCALE_W = 4
) (
    input  logic   clk_i,
    input  logic   rst_i,
    timer_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                state, state_n;
    logic [WIDTH-1:0]      count, count_n;
    logic [PRESCALE_W-1:0] pcnt, pcnt_n;
    logic [WIDTH-1:0]      sh_load, sh_load_n;
    logic [PRESCALE_W-1:0] sh_presc, sh_presc_n;
    logic                  sh_mode, sh_mode_n;
    logic                  sh_dir, sh_dir_n;
    logic                  tick, tick_n;
    logic                  done, done_n;
    logic                  busy, busy_n;
    logic [WIDTH-1:0]      end_val, start_val;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= S_IDLE;
            count    <= '0;
            pcnt     <= '0;
            sh_load  <= '0;
            sh_presc <= '0;
            sh_mode  <= 1'b0;
            sh_dir   <= 1'b0;
            tick     <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            count    <= count_n;
            pcnt     <= pcnt_n;
            sh_load  <= sh_load_n;
            sh_presc <= sh_presc_n;
            sh_mode  <= sh_mode_n;
            sh_dir   <= sh_dir_n;
            tick     <= tick_n;
            done     <= done_n;
            busy     <= busy_n;
        end
    end

    always_comb begin
        state_n    = state;
        count_n    = count;
        pcnt_n     = pcnt;
        sh_load_n  = sh_load;
        sh_presc_n = sh_presc;
        sh_mode_n  = sh_mode;
        sh_dir_n   = sh_dir;
        tick_n     = 1'b0;
        done_n     = 1'b0;
        end_val    = sh_dir ? '0 : sh_load;
        start_val  = sh_dir ? sh_load : '0;

        case (state)
            S_IDLE: begin
                if (bus.start && !bus.stop) begin
                    sh_load_n  = bus.load_val;
                    sh_presc_n = bus.prescale;
                    sh_mode_n  = bus.mode;
                    sh_dir_n   = bus.dir;
                    count_n    = bus.dir ? bus.load_val : '0;
                    pcnt_n     = '0;
                    state_n    = S_RUN;
                end
            end
            // PAUSE with pause released behaves as a RUN cycle, so a pause
            // costs exactly as many cycles as pause was held.
            S_RUN, S_PAUSE: begin
                if (bus.stop) begin
                    state_n = S_IDLE;
                end else if (bus.pause) begin
                    state_n = S_PAUSE;
                end else begin
                    state_n = S_RUN;
                    if (pcnt != sh_presc) begin
                        pcnt_n = pcnt + PRESCALE_W'(1);
                    end else begin
                        pcnt_n = '0;
                        if (count != end_val) begin
                            count_n = sh_dir ? count - WIDTH'(1) : count + WIDTH'(1);
                        end else begin
                            tick_n = 1'b1;
                            if (sh_mode) begin
                                count_n = start_val;
                            end else begin
                                done_n  = 1'b1;
                                state_n = S_DONE;
                            end
                        end
                    end
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        busy_n = (state_n == S_RUN) || (state_n == S_PAUSE);
    end

    assign bus.count = count;
    assign bus.busy  = busy;
    assign bus.tick  = tick;
    assign bus.done  = done;
    assign bus.state = state;
endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl: each task drives one scenario and checks
// outputs 1 time unit after the rising edge against hand-computed values.
module tb_timer_ctrl;
    logic clk;
    logic rst;
    int   vecs;
    int   errs;

    timer_if #(.WIDTH(4), .PRESCALE_W(4)) bus ();

    timer_ctrl #(.WIDTH(4), .PRESCALE_W(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        bus.pause    = 1'b0;
        bus.load_val = 4'd0;
        bus.prescale = 4'd0;
        bus.mode     = 1'b0;
        bus.dir      = 1'b0;
    endtask

    task automatic do_start(input logic [3:0] ld, input logic [3:0] ps,
                            input logic md, input logic dr);
        bus.load_val = ld;
        bus.prescale = ps;
        bus.mode     = md;
        bus.dir      = dr;
        bus.start    = 1'b1;
        step();
        bus.start    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        vecs++; if (bus.state !== 2'd0) begin errs++; $display("FAIL rst_state: got %0d expected 0", bus.state); end
        vecs++; if (bus.count !== 4'd0) begin errs++; $display("FAIL rst_count: got %0d expected 0", bus.count); end
        vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
        vecs++; if (bus.tick !== 1'b0 || bus.done !== 1'b0) begin errs++; $display("FAIL rst_pulses: got tick=%b done=%b expected 0/0", bus.tick, bus.done); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_oneshot_down();
        logic [3:0] exp_c;
        do_start(4'd3, 4'd0, 1'b0, 1'b1);
        vecs++; if (bus.count !== 4'd3) begin errs++; $display("FAIL os_start_count: got %0d expected 3", bus.count); end
        vecs++; if (bus.busy !== 1'b1 || bus.state !== 2'd1) begin errs++; $display("FAIL os_start_state: got busy=%b state=%0d expected 1/1", bus.busy, bus.state); end
        for (int i = 1; i <= 3; i++) begin
            step();
            exp_c = 4'(3 - i);
            vecs++; if (bus.count !== exp_c || bus.tick !== 1'b0) begin errs++; $display("FAIL os_count[%0d]: got %0d tick=%b expected %0d tick=0", i, bus.count, bus.tick, exp_c); end
        end
        step();
        vecs++; if (bus.tick !== 1'b1 || bus.done !== 1'b1) begin errs++; $display("FAIL os_terminal_pulses: got tick=%b done=%b expected 1/1", bus.tick, bus.done); end
        vecs++; if (bus.state !== 2'd3 || bus.busy !== 1'b0 || bus.count !== 4'd0) begin errs++; $display("FAIL os_done_state: got state=%0d busy=%b count=%0d expected 3/0/0", bus.state, bus.busy, bus.count); end
        step();
        vecs++; if (bus.state !== 2'd0 || bus.tick !== 1'b0 || bus.done !== 1'b0 || bus.count !== 4'd0) begin errs++; $display("FAIL os_back_idle: got state=%0d tick=%b done=%b count=%0d expected 0/0/0/0", bus.state, bus.tick, bus.done, bus.count); end
    endtask

    task automatic test_periodic_up();
        logic [3:0] exp_cnt [14] = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd0,
                                     4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd0, 4'd0};
        logic exp_tick;
        do_start(4'd2, 4'd1, 1'b1, 1'b0);
        for (int i = 0; i < 14; i++) begin
            if (i > 0) step();
            exp_tick = (i == 6 || i == 12);
            vecs++; if (bus.count !== exp_cnt[i] || bus.tick !== exp_tick || bus.busy !== 1'b1) begin
                errs++; $display("FAIL pu_seq[%0d]: got count=%0d tick=%b busy=%b expected %0d/%b/1", i, bus.count, bus.tick, bus.busy, exp_cnt[i], exp_tick);
            end
        end
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        vecs++; if (bus.state !== 2'd0 || bus.busy !== 1'b0 || bus.tick !== 1'b0) begin errs++; $display("FAIL pu_stop: got state=%0d busy=%b tick=%b expected 0/0/0", bus.state, bus.busy, bus.tick); end
    endtask

    task automatic test_pause();
        logic [3:0] exp_cnt [4] = '{4'd2, 4'd1, 4'd0, 4'd5};
        logic exp_tick;
        do_start(4'd5, 4'd0, 1'b1, 1'b1);
        step();
        step();
        vecs++; if (bus.count !== 4'd3) begin errs++; $display("FAIL pa_pre_count: got %0d expected 3", bus.count); end
        bus.pause = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            vecs++; if (bus.state !== 2'd2 || bus.count !== 4'd3 || bus.busy !== 1'b1 || bus.tick !== 1'b0) begin
                errs++; $display("FAIL pa_hold[%0d]: got state=%0d count=%0d busy=%b tick=%b expected 2/3/1/0", i, bus.state, bus.count, bus.busy, bus.tick);
            end
        end
        bus.pause = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            exp_tick = (i == 3);
            vecs++; if (bus.count !== exp_cnt[i] || bus.tick !== exp_tick || bus.state !== 2'd1) begin
                errs++; $display("FAIL pa_resume[%0d]: got count=%0d tick=%b state=%0d expected %0d/%b/1", i, bus.count, bus.tick, bus.state, exp_cnt[i], exp_tick);
            end
        end
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        vecs++; if (bus.state !== 2'd0 || bus.count !== 4'd5) begin errs++; $display("FAIL pa_stop: got state=%0d count=%0d expected 0/5", bus.state, bus.count); end
    endtask

    task automatic test_stop_terminal();
        do_start(4'd1, 4'd0, 1'b0, 1'b1);
        step();
        vecs++; if (bus.count !== 4'd0 || bus.state !== 2'd1) begin errs++; $display("FAIL st_pre: got count=%0d state=%0d expected 0/1", bus.count, bus.state); end
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        vecs++; if (bus.state !== 2'd0 || bus.tick !== 1'b0 || bus.done !== 1'b0 || bus.count !== 4'd0 || bus.busy !== 1'b0) begin
            errs++; $display("FAIL st_stop: got state=%0d tick=%b done=%b count=%0d busy=%b expected 0/0/0/0/0", bus.state, bus.tick, bus.done, bus.count, bus.busy);
        end
        step();
        vecs++; if (bus.tick !== 1'b0 || bus.done !== 1'b0 || bus.state !== 2'd0) begin errs++; $display("FAIL st_after: got tick=%b done=%b state=%0d expected 0/0/0", bus.tick, bus.done, bus.state); end
    endtask

    task automatic test_load_zero();
        do_start(4'd0, 4'd0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            vecs++; if (bus.tick !== 1'b1 || bus.count !== 4'd0 || bus.busy !== 1'b1) begin
                errs++; $display("FAIL lz_tick[%0d]: got tick=%b count=%0d busy=%b expected 1/0/1", i, bus.tick, bus.count, bus.busy);
            end
        end
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        vecs++; if (bus.state !== 2'd0 || bus.tick !== 1'b0) begin errs++; $display("FAIL lz_stop: got state=%0d tick=%b expected 0/0", bus.state, bus.tick); end
    endtask

    task automatic test_back_to_back();
        do_start(4'd3, 4'd0, 1'b1, 1'b1);
        step();
        bus.start    = 1'b1;
        bus.load_val = 4'd7;
        bus.mode     = 1'b0;
        bus.dir      = 1'b0;
        step();
        bus.start    = 1'b0;
        vecs++; if (bus.count !== 4'd1 || bus.state !== 2'd1) begin errs++; $display("FAIL bb_ignored: got count=%0d state=%0d expected 1/1", bus.count, bus.state); end
        step();
        step();
        vecs++; if (bus.tick !== 1'b1 || bus.count !== 4'd3 || bus.state !== 2'd1) begin
            errs++; $display("FAIL bb_reload: got tick=%b count=%0d state=%0d expected 1/3/1", bus.tick, bus.count, bus.state);
        end
        bus.stop = 1'b1;
        step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        vecs++; if (bus.state !== 2'd0 || bus.busy !== 1'b0) begin errs++; $display("FAIL bb_stop_wins: got state=%0d busy=%b expected 0/0", bus.state, bus.busy); end
    endtask

    task automatic test_async_reset();
        do_start(4'd7, 4'd0, 1'b1, 1'b0);
        step();
        step();
        step();
        vecs++; if (bus.count !== 4'd3) begin errs++; $display("FAIL ar_pre: got count=%0d expected 3", bus.count); end
        #2;
        rst = 1'b1;
        #1;
        vecs++; if (bus.count !== 4'd0 || bus.state !== 2'd0 || bus.busy !== 1'b0 || bus.tick !== 1'b0 || bus.done !== 1'b0) begin
            errs++; $display("FAIL ar_clear: got count=%0d state=%0d busy=%b tick=%b done=%b expected all 0", bus.count, bus.state, bus.busy, bus.tick, bus.done);
        end
        #1;
        rst = 1'b0;
        step();
        vecs++; if (bus.state !== 2'd0) begin errs++; $display("FAIL ar_idle: got state=%0d expected 0", bus.state); end
        do_start(4'd2, 4'd0, 1'b0, 1'b0);
        step();
        step();
        vecs++; if (bus.count !== 4'd2 || bus.tick !== 1'b0) begin errs++; $display("FAIL ar_up_count: got count=%0d tick=%b expected 2/0", bus.count, bus.tick); end
        step();
        vecs++; if (bus.tick !== 1'b1 || bus.done !== 1'b1 || bus.state !== 2'd3 || bus.count !== 4'd2) begin
            errs++; $display("FAIL ar_up_done: got tick=%b done=%b state=%0d count=%0d expected 1/1/3/2", bus.tick, bus.done, bus.state, bus.count);
        end
        step();
        vecs++; if (bus.state !== 2'd0 || bus.done !== 1'b0 || bus.count !== 4'd2) begin errs++; $display("FAIL ar_up_idle: got state=%0d done=%b count=%0d expected 0/0/2", bus.state, bus.done, bus.count); end
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        test_reset();
        test_oneshot_down();
        test_periodic_up();
        test_pause();
        test_stop_terminal();
        test_load_zero();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
